// File: rtl/ps2_receiver_pkg.sv
// Shared types for the PS/2 receive path.
// Frame geometry and receiver FSM state encoding.
package ps2_receiver_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef logic [PS2_DATA_BITS-1:0] Scancode_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } Ps2RxState_t;

endpackage

// File: rtl/ps2_input_filter.sv
// Synchroniser plus debounce for W asynchronous pins.
// Bit 0 additionally produces a one-cycle falling-edge strobe.
module ps2_input_filter #(
    parameter int W           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_pin,
    output logic [W-1:0] o_level,
    output logic         o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync [W];
    logic [CW-1:0]          r_cnt  [W];
    logic [W-1:0]           r_level;
    logic                   r_fall;
    logic [W-1:0]           w_sample;
    logic [W-1:0]           w_diff;
    logic [W-1:0]           w_flip;

    always_comb begin
        for (int b = 0; b < W; b++) begin
            w_sample[b] = r_sync[b][SYNC_STAGES-1];
            w_diff[b]   = w_sample[b] != r_level[b];
            w_flip[b]   = w_diff[b] && (r_cnt[b] == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < W; b++) begin
                r_sync[b] <= '1;
                r_cnt[b]  <= '0;
            end
            r_level <= '1;
            r_fall  <= 1'b0;
        end else begin
            for (int b = 0; b < W; b++) begin
                r_sync[b] <= {r_sync[b][SYNC_STAGES-2:0], i_pin[b]};
                if (w_flip[b]) begin
                    r_level[b] <= w_sample[b];
                    r_cnt[b]   <= '0;
                end else if (w_diff[b]) begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end else begin
                    r_cnt[b] <= '0;
                end
            end
            r_fall <= w_flip[0] && r_level[0];
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with mid-frame timeout.
// Define PS2_RX_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ps2_clk,
    input  logic      ps2_data,
    output Scancode_t scancode,
    output logic      scancodeDone,
    output logic      frameError,
    output logic      busy
);

    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]  w_level;
    logic        w_fall;
    logic        w_data;

    Ps2RxState_t r_state, w_state_nxt;
    logic [BW-1:0] r_bitcnt, w_bitcnt_nxt;
    Scancode_t   r_shift, w_shift_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    Scancode_t   r_scancode;
    logic        r_done, r_err;
    logic        w_acc, w_rej;
    logic        w_par_ok;

    ps2_input_filter #(
        .W          (2),
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  ({ps2_data, ps2_clk}),
        .o_level(w_level),
        .o_fall (w_fall)
    );

    assign w_data = w_level[1];

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_parity, w_parity_nxt;
    assign w_par_ok = ^{r_shift, r_parity};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_parity <= 1'b0;
        else        r_parity <= w_parity_nxt;
    end
    always_comb begin
        w_parity_nxt = r_parity;
        if (r_state == PARITY && w_fall && r_tcnt != T_LAST)
            w_parity_nxt = w_data;
    end
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_tcnt_nxt   = '0;
        w_acc        = 1'b0;
        w_rej        = 1'b0;
        if (r_state != IDLE && r_tcnt == T_LAST) begin
            // Expiry beats a coincident edge; partial byte is dropped.
            w_state_nxt = IDLE;
            w_rej       = 1'b1;
        end else begin
            if (r_state != IDLE)
                w_tcnt_nxt = w_fall ? '0 : r_tcnt + 1'b1;
            if (w_fall) begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            w_state_nxt  = DATA;
                            w_bitcnt_nxt = '0;
                        end
                    end
                    DATA: begin
                        w_shift_nxt[r_bitcnt] = w_data;
                        if (r_bitcnt == BIT_LAST) w_state_nxt = PARITY;
                        else w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                    PARITY: w_state_nxt = STOP;
                    STOP: begin
                        w_state_nxt = IDLE;
                        w_acc = w_data && w_par_ok;
                        w_rej = !(w_data && w_par_ok);
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_tcnt     <= '0;
            r_scancode <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_done   <= w_acc;
            r_err    <= w_rej;
            if (w_acc) r_scancode <= r_shift;
        end
    end

    assign scancode     = r_scancode;
    assign scancodeDone = r_done;
    assign frameError   = r_err;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with scaled-down PS/2 timing.
// Honours PS2_RX_PARITY_CHECK_EN for the bad-parity case.
module tb_ps2_receiver;

    localparam int SYNC = 2;
    localparam int FLEN = 8;
    localparam int TOUT = 1000;
    localparam int H    = 40;
    localparam int LAT  = SYNC + FLEN + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancodeDone;
    logic       frameError;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int edge_cyc = 0;
    logic [7:0] codes [$];

    ps2_receiver #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FLEN),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scancode    (scancode),
        .scancodeDone(scancodeDone),
        .frameError  (frameError),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (scancodeDone) begin
                n_done++;
                codes.push_back(scancode);
                done_cyc = cyc;
            end
            if (frameError) begin
                n_err++;
                err_cyc = cyc;
            end
            if (scancodeDone && frameError) n_both++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_done = 0;
        n_err  = 0;
        codes.delete();
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic pbad,
                                       input logic stop);
        return {stop, (~^d) ^ pbad, d, 1'b0};
    endfunction

    // Drives the first nb slots of fr; optional short glitch on one slot.
    task automatic send(input logic [10:0] fr, input int nb, input int gl);
        for (int i = 0; i < nb; i++) begin
            ps2_data = fr[i];
            if (i == gl) begin
                tick(4);
                ps2_clk = 1'b0;
                tick(FLEN - 1);
                ps2_clk = 1'b1;
                tick(H / 2 - 4 - (FLEN - 1));
            end else begin
                tick(H / 2);
            end
            ps2_clk = 1'b0;
            edge_cyc = cyc;
            tick(H);
            ps2_clk = 1'b1;
            tick(H / 2);
        end
    endtask

    initial begin
        tick(5);
        check("rst_scancode", scancode, 8'h00);
        check("rst_done", scancodeDone, 0);
        check("rst_err", frameError, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(5);

        clr();
        send(mk(8'h1C, 1'b1, 1'b1), 11, -1);
        tick(20);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("par_err", n_err, 1);
        check("par_done", n_done, 0);
        check("par_code", scancode, 8'h00);
`else
        check("par_err", n_err, 0);
        check("par_done", n_done, 1);
        check("par_code", scancode, 8'h1C);
`endif

        clr();
        send(mk(8'h1C, 1'b0, 1'b1), 11, -1);
        tick(20);
        check("c1_done", n_done, 1);
        check("c1_err", n_err, 0);
        check("c1_code", scancode, 8'h1C);
        check("c1_lat", done_cyc - edge_cyc, LAT);
        check("c1_busy", busy, 0);

        clr();
        send(mk(8'hF0, 1'b0, 1'b1), 11, -1);
        send(mk(8'h1C, 1'b0, 1'b1), 11, -1);
        tick(20);
        check("b2b_done", n_done, 2);
        check("b2b_err", n_err, 0);
        if (codes.size() == 2) begin
            check("b2b_c0", codes[0], 8'hF0);
            check("b2b_c1", codes[1], 8'h1C);
        end else begin
            check("b2b_qsize", codes.size(), 2);
        end

        clr();
        send(mk(8'h33, 1'b0, 1'b0), 11, -1);
        tick(20);
        check("stop_err", n_err, 1);
        check("stop_done", n_done, 0);
        check("stop_lat", err_cyc - edge_cyc, LAT);
        clr();
        send(mk(8'h5A, 1'b0, 1'b1), 11, -1);
        tick(20);
        check("5a_done", n_done, 1);
        check("5a_code", scancode, 8'h5A);

        clr();
        send(mk(8'hA5, 1'b0, 1'b1), 5, -1);
        ps2_data = 1'b1;
        tick(10);
        check("to_busy_mid", busy, 1);
        for (int k = 0; k < 3 * TOUT && n_err == 0; k++) tick(1);
        tick(2);
        check("to_err", n_err, 1);
        check("to_lat", err_cyc - edge_cyc, TOUT + LAT);
        check("to_busy", busy, 0);
        check("to_done", n_done, 0);
        clr();
        send(mk(8'h29, 1'b0, 1'b1), 11, -1);
        tick(20);
        check("29_done", n_done, 1);
        check("29_code", scancode, 8'h29);
        check("29_err", n_err, 0);

        clr();
        send(mk(8'h76, 1'b0, 1'b1), 11, 4);
        tick(20);
        check("gl_done", n_done, 1);
        check("gl_code", scancode, 8'h76);
        check("gl_err", n_err, 0);

        clr();
        send(mk(8'h44, 1'b0, 1'b1), 4, -1);
        ps2_data = 1'b1;
        tick(5);
        check("rm_busy_pre", busy, 1);
        rst_n = 1'b0;
        tick(1);
        check("rm_code", scancode, 8'h00);
        check("rm_busy", busy, 0);
        check("rm_done", scancodeDone, 0);
        tick(4);
        rst_n = 1'b1;
        tick(2 * TOUT);
        check("rm_nostrobe", n_done + n_err, 0);
        send(mk(8'h12, 1'b0, 1'b1), 11, -1);
        tick(20);
        check("12_done", n_done, 1);
        check("12_code", scancode, 8'h12);
        check("12_err", n_err, 0);
        check("never_both", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
